eth_rx_deframer: RTL and testbench

// Downstream of the RMII receive driver. Packs its dibit stream into bytes (LSB dibit first),

---
 rtl/eth_rx_deframer_pkg.sv | 23 ++
 rtl/crc32_byte.sv | 21 ++
 rtl/eth_rx_deframer.sv | 103 ++++++++++
 tb/tb_eth_rx_deframer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_deframer_pkg.sv
// Shared constants and CRC-32 helper for the Ethernet receive path.
package eth_rx_deframer_pkg;

    localparam int unsigned DIBIT_W  = 2;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned CRC_W    = 32;
    localparam int unsigned HB_DEPTH = 4;
    localparam int unsigned FILL_W   = 3;

    localparam logic [CRC_W-1:0] CRC32_POLY_REFL   = 32'hEDB88320;
    localparam logic [CRC_W-1:0] CRC32_INIT        = 32'hFFFFFFFF;
    localparam logic [CRC_W-1:0] CRC32_RESIDUE     = 32'hDEBB20E3;
    localparam int unsigned      ETH_MIN_FRAME_LEN = 64;

    // One bit of the reflected CRC-32 shift register.
    function automatic logic [CRC_W-1:0] crc32_bit_step(input logic [CRC_W-1:0] crc,
                                                        input logic             din);
        logic w_fb;
        w_fb = crc[0] ^ din;
        return (crc >> 1) ^ (CRC32_POLY_REFL & {CRC_W{w_fb}});
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational CRC-32 advance by one byte, LSB first; shared by RX check and TX FCS insertion.
module crc32_byte
    import eth_rx_deframer_pkg::*;
(
    input  logic [CRC_W-1:0]  crc,
    input  logic [BYTE_W-1:0] data,
    output logic [CRC_W-1:0]  crc_next
);

    logic [CRC_W-1:0] w_crc;

    // Eight reflected bit steps, data bit 0 first.
    always_comb begin
        w_crc = crc;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            w_crc = crc32_bit_step(w_crc, data[i]);
        end
        crc_next = w_crc;
    end

endmodule

// File: rtl/eth_rx_deframer.sv
// RMII dibit-to-byte deframer: packs bytes, checks CRC-32, strips the trailing FCS
// and reports length / CRC / framing status at frame end.
module eth_rx_deframer
    import eth_rx_deframer_pkg::*;
#(
    parameter int unsigned MIN_FRAME_LEN = ETH_MIN_FRAME_LEN,
    parameter int unsigned MAX_LEN_BITS  = 11
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [1:0]              in,
    input  logic                    inclk,
    input  logic                    in_done,
    output logic [7:0]              out,
    output logic                    outclk,
    output logic                    frame_done,
    output logic [MAX_LEN_BITS-1:0] frame_len,
    output logic                    crc_ok,
    output logic                    align_err,
    output logic                    runt_err
);

    // Only three earlier dibits are needed; the fourth arrives live on 'in'.
    logic [BYTE_W-DIBIT_W-1:0] r_sr;
    logic [1:0]                r_dibit_cnt;
    logic [FILL_W-1:0]         r_fill;
    logic [CRC_W-1:0]          r_crc;
    logic [MAX_LEN_BITS-1:0]   r_len;
    logic [BYTE_W-1:0]         r_hb [HB_DEPTH];

    logic [BYTE_W-1:0]         w_byte;
    logic                      w_byte_done;
    logic [CRC_W-1:0]          w_crc_next;
    logic                      w_runt;

    assign w_byte      = {in, r_sr};
    assign w_byte_done = inclk && (r_dibit_cnt == 2'd3);
    assign w_runt      = (32'(r_len) < MIN_FRAME_LEN);

    crc32_byte u_crc32_byte (
        .crc      (r_crc),
        .data     (w_byte),
        .crc_next (w_crc_next)
    );

    // Packer, CRC register, FCS holdback, length counter and frame-end status.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sr        <= '0;
            r_dibit_cnt <= '0;
            r_fill      <= '0;
            r_crc       <= CRC32_INIT;
            r_len       <= '0;
            for (int i = 0; i < int'(HB_DEPTH); i++) begin
                r_hb[i] <= '0;
            end
            out         <= '0;
            outclk      <= 1'b0;
            frame_done  <= 1'b0;
            frame_len   <= '0;
            crc_ok      <= 1'b0;
            align_err   <= 1'b0;
            runt_err    <= 1'b0;
        end else begin
            outclk     <= 1'b0;
            frame_done <= 1'b0;
            if (in_done) begin
                // Frame end wins over a coincident dibit; any partial byte is discarded.
                frame_done  <= 1'b1;
                frame_len   <= r_len;
                crc_ok      <= (r_crc == CRC32_RESIDUE);
                align_err   <= (r_dibit_cnt != 2'd0);
                runt_err    <= w_runt;
                r_sr        <= '0;
                r_dibit_cnt <= '0;
                r_fill      <= '0;
                r_len       <= '0;
                r_crc       <= CRC32_INIT;
            end else if (inclk) begin
                r_sr        <= w_byte[BYTE_W-1:DIBIT_W];
                r_dibit_cnt <= r_dibit_cnt + 2'd1;
                if (w_byte_done) begin
                    r_crc <= w_crc_next;
                    // Release the oldest held byte only once four newer ones exist.
                    if (r_fill == FILL_W'(HB_DEPTH)) begin
                        out    <= r_hb[HB_DEPTH-1];
                        outclk <= 1'b1;
                    end else begin
                        r_fill <= r_fill + FILL_W'(1);
                    end
                    r_hb[0] <= w_byte;
                    for (int i = 1; i < int'(HB_DEPTH); i++) begin
                        r_hb[i] <= r_hb[i-1];
                    end
                    if (r_len != '1) begin
                        r_len <= r_len + MAX_LEN_BITS'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_deframer.sv
// Scoreboard bench for eth_rx_deframer: payload bytes and frame status are queued
// when a frame is driven and compared as outclk / frame_done appear.
module tb_eth_rx_deframer;

    localparam int unsigned LEN_W   = 11;
    localparam int          LEN_MAX = 2047;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [1:0]       d_in = 2'd0;
    logic             d_inclk = 1'b0;
    logic             d_in_done = 1'b0;
    logic [7:0]       out;
    logic             outclk;
    logic             frame_done;
    logic [LEN_W-1:0] frame_len;
    logic             crc_ok;
    logic             align_err;
    logic             runt_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int len;
        bit ok;
        bit al;
        bit rn;
    } stat_t;

    logic [7:0] exp_q [$];
    stat_t      stat_q [$];
    logic [7:0] fb [$];

    eth_rx_deframer #(
        .MIN_FRAME_LEN (64),
        .MAX_LEN_BITS  (LEN_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in         (d_in),
        .inclk      (d_inclk),
        .in_done    (d_in_done),
        .out        (out),
        .outclk     (outclk),
        .frame_done (frame_done),
        .frame_len  (frame_len),
        .crc_ok     (crc_ok),
        .align_err  (align_err),
        .runt_err   (runt_err)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference CRC-32 (reflected, init all-ones, no final inversion).
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            if (r[0]) r = (r >> 1) ^ 32'hEDB88320;
            else      r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_of_fb();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (fb[i]) c = crc_upd(c, fb[i]);
        return c;
    endfunction

    task automatic build_seq(input int start, input int n);
        fb = {};
        for (int i = 0; i < n; i++) fb.push_back(8'(start + i));
    endtask

    task automatic append_fcs();
        logic [31:0] fcs;
        fcs = ~crc_of_fb();
        fb.push_back(fcs[7:0]);
        fb.push_back(fcs[15:8]);
        fb.push_back(fcs[23:16]);
        fb.push_back(fcs[31:24]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            d_inclk   = 1'b0;
            d_in_done = 1'b0;
        end
    endtask

    task automatic send_dibit(input logic [1:0] d, input bit gaps);
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            @(negedge clk);
            d_inclk   = 1'b0;
            d_in_done = 1'b0;
        end
        @(negedge clk);
        d_in      = d;
        d_inclk   = 1'b1;
        d_in_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        for (int k = 0; k < 4; k++) send_dibit(b[2*k +: 2], gaps);
    endtask

    // Drives fb as one frame plus 'extra' stray dibits; leaves in_done high for one cycle.
    task automatic send_frame(input int extra, input bit done_inclk, input bit gaps);
        stat_t s;
        int    n;
        n = fb.size();
        for (int i = 0; i < n - 4; i++) exp_q.push_back(fb[i]);
        s.len = (n > LEN_MAX) ? LEN_MAX : n;
        s.ok  = (crc_of_fb() == 32'hDEBB20E3);
        s.al  = ((extra % 4) != 0);
        s.rn  = (s.len < 64);
        stat_q.push_back(s);
        for (int i = 0; i < n; i++) send_byte(fb[i], gaps);
        for (int i = 0; i < extra; i++) send_dibit(2'($urandom_range(0, 3)), gaps);
        @(negedge clk);
        d_in      = 2'($urandom_range(0, 3));
        d_inclk   = done_inclk;
        d_in_done = 1'b1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_out"},        32'(out),        32'd0);
        chk({tag, "_outclk"},     32'(outclk),     32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_len"},  32'(frame_len),  32'd0);
        chk({tag, "_crc_ok"},     32'(crc_ok),     32'd0);
        chk({tag, "_align_err"},  32'(align_err),  32'd0);
        chk({tag, "_runt_err"},   32'(runt_err),   32'd0);
    endtask

    // Output monitor: pops the scoreboard on every strobe.
    always @(negedge clk) begin : mon
        stat_t      s;
        logic [7:0] e;
        if (outclk) begin
            chk("out_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_byte", 32'(out), 32'(e));
            end
        end
        if (frame_done) begin
            chk("done_pending", 32'(stat_q.size() > 0), 32'd1);
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("frame_len", 32'(frame_len), 32'(s.len));
                chk("crc_ok",    32'(crc_ok),    32'(s.ok));
                chk("align_err", 32'(align_err), 32'(s.al));
                chk("runt_err",  32'(runt_err),  32'(s.rn));
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        idle(2);

        // "123456789" with its known FCS
        fb = {};
        for (int i = 0; i < 9; i++) fb.push_back(8'(8'h31 + i));
        fb.push_back(8'h26); fb.push_back(8'h39); fb.push_back(8'hF4); fb.push_back(8'hCB);
        send_frame(0, 1'b0, 1'b0);
        idle(3);

        // Minimum-length good frame, with idle gaps in the dibit stream
        build_seq(0, 60);
        append_fcs();
        send_frame(0, 1'b0, 1'b1);
        idle(3);

        // Corrupted payload bit
        build_seq(0, 60);
        append_fcs();
        fb[10] = fb[10] ^ 8'h01;
        send_frame(0, 1'b0, 1'b0);
        idle(3);

        // Two stray dibits before frame end
        build_seq(0, 60);
        append_fcs();
        send_frame(2, 1'b0, 1'b0);
        idle(3);

        // Frame end with nothing received
        fb = {};
        send_frame(0, 1'b0, 1'b0);
        idle(3);

        // Short frame: no payload released
        build_seq(8'hA0, 3);
        send_frame(0, 1'b0, 1'b0);
        idle(3);

        // Frame end coincident with a dibit: the dibit must be dropped
        build_seq(8'h10, 60);
        append_fcs();
        send_frame(0, 1'b1, 1'b0);
        idle(3);

        // Length counter saturation
        build_seq(0, 2046);
        append_fcs();
        send_frame(0, 1'b0, 1'b0);
        idle(3);

        // Back-to-back frames, second starts the cycle after in_done
        build_seq(0, 60);
        append_fcs();
        send_frame(0, 1'b0, 1'b0);
        send_frame(0, 1'b0, 1'b0);
        idle(3);

        // Reset in mid-frame: 16 bytes escape the holdback, no status reported
        build_seq(0, 60);
        append_fcs();
        for (int i = 0; i < 16; i++) exp_q.push_back(fb[i]);
        for (int i = 0; i < 20; i++) send_byte(fb[i], 1'b0);
        idle(1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        idle(2);
        rstn = 1'b1;
        idle(2);
        send_frame(0, 1'b0, 1'b0);
        idle(20);

        // Status holds after the pulse; all expectations consumed
        chk("hold_frame_len", 32'(frame_len), 32'd64);
        chk("hold_crc_ok",    32'(crc_ok),    32'd1);
        chk("bytes_left",     32'(exp_q.size()),  32'd0);
        chk("status_left",    32'(stat_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
